// File: rtl/pipeline_controller.sv
// pipeline_controller: RV32I-subset decode, branch resolution, IF/ID flush, RUN/HALT FSM and perf counters.
// Latency: sel/flush/alu_src/alu_op are combinational; regwq/memwq/memrq/mem2regq follow decode by one cycle.
// Backpressure: none; a halt request parks the FSM in HALT, which flushes every cycle until reset.
module pipeline_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       inst_control,
  input  logic [9:0]       inst_alu,
  input  logic             zero_flag,
  output logic             sel,
  output logic             alu_src,
  output logic [3:0]       alu_op,
  output logic             flush,
  output logic             regwq,
  output logic             memwq,
  output logic             memrq,
  output logic             mem2regq,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_BUBBLE = 7'h00;
  localparam logic [6:0] OP_LW     = 7'h03;
  localparam logic [6:0] OP_IALU   = 7'h13;
  localparam logic [6:0] OP_SW     = 7'h23;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_BR     = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [6:0]       w_funct7;
  logic [2:0]       w_funct3;
  logic             w_alu_src;
  logic [3:0]       w_alu_op;
  logic             w_regw;
  logic             w_memw;
  logic             w_memr;
  logic             w_mem2reg;
  logic             w_taken;
  logic             w_jump;
  logic             w_legal;
  logic             w_halt_req;
  logic             w_run;
  logic             r_regw;
  logic             r_memw;
  logic             r_memr;
  logic             r_mem2reg;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_flushes;

  assign w_funct7 = inst_alu[9:3];
  assign w_funct3 = inst_alu[2:0];
  assign w_run    = (r_state == ST_RUN);

  // funct3 -> ALU op; alt selects SUB/SRA over ADD/SRL
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Instruction decode and branch resolution; bubbles and unknown opcodes decode to all-zero controls
  always_comb begin
    w_alu_src  = 1'b0;
    w_alu_op   = ALU_AND;
    w_regw     = 1'b0;
    w_memw     = 1'b0;
    w_memr     = 1'b0;
    w_mem2reg  = 1'b0;
    w_taken    = 1'b0;
    w_jump     = 1'b0;
    w_legal    = 1'b1;
    w_halt_req = 1'b0;
    case (inst_control)
      OP_BUBBLE: w_legal = 1'b0;
      OP_R: begin
        w_alu_op = alu_map(w_funct3, w_funct7 == 7'h20);
        w_regw   = 1'b1;
      end
      OP_IALU: begin
        w_alu_src = 1'b1;
        w_alu_op  = alu_map(w_funct3, (w_funct3 == 3'b101) && (w_funct7 == 7'h20));
        w_regw    = 1'b1;
      end
      OP_LW: begin
        w_alu_src = 1'b1;
        w_alu_op  = ALU_ADD;
        w_regw    = 1'b1;
        w_memr    = 1'b1;
        w_mem2reg = 1'b1;
      end
      OP_SW: begin
        w_alu_src = 1'b1;
        w_alu_op  = ALU_ADD;
        w_memw    = 1'b1;
      end
      OP_BR: begin
        // zero_flag is the ALU zero of SUB/SLT/SLTU: compare result 0 means equal or not-less
        case (w_funct3)
          3'b000: begin w_alu_op = ALU_SUB;  w_taken = zero_flag;  end
          3'b001: begin w_alu_op = ALU_SUB;  w_taken = !zero_flag; end
          3'b100: begin w_alu_op = ALU_SLT;  w_taken = !zero_flag; end
          3'b101: begin w_alu_op = ALU_SLT;  w_taken = zero_flag;  end
          3'b110: begin w_alu_op = ALU_SLTU; w_taken = !zero_flag; end
          3'b111: begin w_alu_op = ALU_SLTU; w_taken = zero_flag;  end
          default: begin
            w_legal    = 1'b0;
            w_halt_req = 1'b1;
          end
        endcase
      end
      OP_JAL: begin
        w_alu_op = ALU_ADD;
        w_jump   = 1'b1;
      end
      default: begin
        w_legal    = 1'b0;
        w_halt_req = 1'b1;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  // FSM next state and combinational datapath controls; a halt request suppresses redirect
  always_comb begin
    w_state_nxt = r_state;
    sel         = 1'b0;
    flush       = 1'b0;
    alu_src     = w_alu_src;
    alu_op      = w_alu_op;
    case (r_state)
      ST_RUN: begin
        sel   = (w_taken | w_jump) & ~w_halt_req;
        flush = sel;
        if (w_halt_req) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        alu_src = 1'b0;
        alu_op  = ALU_ADD;
        flush   = 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // EX -> MEM/WB control pipeline register; only RUN lets decoded writes through
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regw    <= 1'b0;
      r_memw    <= 1'b0;
      r_memr    <= 1'b0;
      r_mem2reg <= 1'b0;
    end else begin
      r_regw    <= w_run & w_regw;
      r_memw    <= w_run & w_memw;
      r_memr    <= w_run & w_memr;
      r_mem2reg <= w_run & w_mem2reg;
    end
  end

  // Retire and redirect counters, wrapping; both frozen in HALT since w_run and sel are low there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired <= '0;
      r_flushes <= '0;
    end else begin
      if (w_run && w_legal) r_retired <= r_retired + CNT_W'(1);
      if (sel)              r_flushes <= r_flushes + CNT_W'(1);
    end
  end

  assign regwq       = r_regw;
  assign memwq       = r_memw;
  assign memrq       = r_memr;
  assign mem2regq    = r_mem2reg;
  assign halted      = (r_state == ST_HALT);
  assign retired_cnt = r_retired;
  assign flush_cnt   = r_flushes;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a 32-bit-counter instance plus a 4-bit-counter
// instance on the same stimulus, checked against hand-computed expectations.
module tb_pipeline_controller;

  logic        clk;
  logic        rst;
  logic [6:0]  inst_control;
  logic [9:0]  inst_alu;
  logic        zero_flag;

  logic        sel, alu_src, flush, regwq, memwq, memrq, mem2regq, halted;
  logic [3:0]  alu_op;
  logic [31:0] retired_cnt, flush_cnt;

  logic        sel4, alu_src4, flush4, regwq4, memwq4, memrq4, mem2regq4, halted4;
  logic [3:0]  alu_op4;
  logic [3:0]  retired_cnt4, flush_cnt4;

  int n_vec = 0;
  int n_err = 0;

  pipeline_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .inst_control(inst_control), .inst_alu(inst_alu), .zero_flag(zero_flag),
    .sel(sel), .alu_src(alu_src), .alu_op(alu_op), .flush(flush),
    .regwq(regwq), .memwq(memwq), .memrq(memrq), .mem2regq(mem2regq), .halted(halted),
    .retired_cnt(retired_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .inst_control(inst_control), .inst_alu(inst_alu), .zero_flag(zero_flag),
    .sel(sel4), .alu_src(alu_src4), .alu_op(alu_op4), .flush(flush4),
    .regwq(regwq4), .memwq(memwq4), .memrq(memrq4), .mem2regq(mem2regq4), .halted(halted4),
    .retired_cnt(retired_cnt4), .flush_cnt(flush_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [6:0] op, input logic [9:0] alu, input logic z);
    inst_control = op;
    inst_alu     = alu;
    zero_flag    = z;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(7'h03, 10'h000, 1'b0);
    tick(); tick();
    n_vec++;
    if ({regwq, memwq, memrq, mem2regq, halted} !== 5'b00000) begin
      n_err++; $display("FAIL reset_regs: got %b want 00000", {regwq, memwq, memrq, mem2regq, halted});
    end
    n_vec++;
    if ({retired_cnt, flush_cnt} !== 64'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", retired_cnt, flush_cnt);
    end
    n_vec++;
    if ({alu_src, alu_op} !== 5'b1_0010) begin
      n_err++; $display("FAIL reset_comb_lw: got %b want 10010", {alu_src, alu_op});
    end
    rst = 1'b1;
    drive(7'h13, 10'h000, 1'b0);
    tick();
    n_vec++;
    if ({regwq, memwq, memrq, mem2regq} !== 4'b1000 || retired_cnt !== 32'd1) begin
      n_err++; $display("FAIL reset_release_addi: got %b cnt %0d want 1000 cnt 1", {regwq, memwq, memrq, mem2regq}, retired_cnt);
    end
  endtask

  task automatic test_decode;
    logic [9:0] alu_v [5];
    logic [6:0] op_v  [5];
    logic [4:0] exp_v [5];
    op_v[0] = 7'h33; alu_v[0] = {7'h20, 3'b000}; exp_v[0] = 5'b0_0110;  // SUB
    op_v[1] = 7'h33; alu_v[1] = {7'h20, 3'b101}; exp_v[1] = 5'b0_1000;  // SRA
    op_v[2] = 7'h33; alu_v[2] = {7'h00, 3'b011}; exp_v[2] = 5'b0_1001;  // SLTU
    op_v[3] = 7'h13; alu_v[3] = {7'h20, 3'b000}; exp_v[3] = 5'b1_0010;  // ADDI ignores funct7
    op_v[4] = 7'h13; alu_v[4] = {7'h20, 3'b101}; exp_v[4] = 5'b1_1000;  // SRAI
    for (int i = 0; i < 5; i++) begin
      drive(op_v[i], alu_v[i], 1'b0);
      n_vec++;
      if ({alu_src, alu_op, sel, flush} !== {exp_v[i], 2'b00}) begin
        n_err++; $display("FAIL decode_alu[%0d]: got %b want %b", i, {alu_src, alu_op, sel, flush}, {exp_v[i], 2'b00});
      end
      tick();
      n_vec++;
      if ({regwq, memwq, memrq, mem2regq} !== 4'b1000) begin
        n_err++; $display("FAIL decode_regw[%0d]: got %b want 1000", i, {regwq, memwq, memrq, mem2regq});
      end
    end
    drive(7'h03, 10'h000, 1'b0);
    n_vec++;
    if ({alu_src, alu_op, memrq} !== 6'b1_0010_0) begin
      n_err++; $display("FAIL decode_lw_comb: got %b want 100100", {alu_src, alu_op, memrq});
    end
    tick();
    n_vec++;
    if ({regwq, memwq, memrq, mem2regq} !== 4'b1011) begin
      n_err++; $display("FAIL decode_lw_reg: got %b want 1011", {regwq, memwq, memrq, mem2regq});
    end
    drive(7'h23, 10'h000, 1'b0);
    tick();
    n_vec++;
    if ({regwq, memwq, memrq, mem2regq} !== 4'b0100 || retired_cnt !== 32'd8) begin
      n_err++; $display("FAIL decode_sw: got %b cnt %0d want 0100 cnt 8", {regwq, memwq, memrq, mem2regq}, retired_cnt);
    end
  endtask

  task automatic test_branch;
    logic [6:0] op_v  [6];
    logic [9:0] alu_v [6];
    logic       z_v   [6];
    logic [5:0] exp_v [6];   // {sel, flush, alu_op}
    int         exp_ret [6];
    int         exp_fl  [6];
    op_v[0] = 7'h63; alu_v[0] = 10'b000; z_v[0] = 1'b1; exp_v[0] = 6'b11_0110; exp_ret[0] = 9;  exp_fl[0] = 1; // BEQ taken
    op_v[1] = 7'h63; alu_v[1] = 10'b001; z_v[1] = 1'b1; exp_v[1] = 6'b00_0110; exp_ret[1] = 10; exp_fl[1] = 1; // BNE not taken
    op_v[2] = 7'h63; alu_v[2] = 10'b101; z_v[2] = 1'b1; exp_v[2] = 6'b11_0111; exp_ret[2] = 11; exp_fl[2] = 2; // BGE taken
    op_v[3] = 7'h63; alu_v[3] = 10'b110; z_v[3] = 1'b0; exp_v[3] = 6'b11_1001; exp_ret[3] = 12; exp_fl[3] = 3; // BLTU taken
    op_v[4] = 7'h6F; alu_v[4] = 10'b000; z_v[4] = 1'b0; exp_v[4] = 6'b11_0010; exp_ret[4] = 13; exp_fl[4] = 4; // JAL
    op_v[5] = 7'h00; alu_v[5] = 10'b000; z_v[5] = 1'b1; exp_v[5] = 6'b00_0000; exp_ret[5] = 13; exp_fl[5] = 4; // bubble
    n_vec++;
    if (flush_cnt !== 32'd0) begin
      n_err++; $display("FAIL branch_flush_start: got %0d want 0", flush_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      drive(op_v[i], alu_v[i], z_v[i]);
      n_vec++;
      if ({sel, flush, alu_op} !== exp_v[i]) begin
        n_err++; $display("FAIL branch_comb[%0d]: got %b want %b", i, {sel, flush, alu_op}, exp_v[i]);
      end
      tick();
      n_vec++;
      if (retired_cnt !== 32'(exp_ret[i]) || flush_cnt !== 32'(exp_fl[i]) || regwq !== 1'b0 || halted !== 1'b0) begin
        n_err++; $display("FAIL branch_reg[%0d]: got ret %0d fl %0d regwq %b halted %b want ret %0d fl %0d 0 0",
                          i, retired_cnt, flush_cnt, regwq, halted, exp_ret[i], exp_fl[i]);
      end
    end
  endtask

  task automatic test_halt;
    drive(7'h23, 10'h000, 1'b0);
    tick();
    drive(7'h73, 10'h000, 1'b0);
    n_vec++;
    if ({sel, flush, memwq, halted} !== 4'b0010) begin
      n_err++; $display("FAIL halt_req_cycle: got %b want 0010", {sel, flush, memwq, halted});
    end
    tick();
    n_vec++;
    if ({regwq, memwq, memrq, mem2regq, halted, flush} !== 6'b000011) begin
      n_err++; $display("FAIL halt_enter: got %b want 000011", {regwq, memwq, memrq, mem2regq, halted, flush});
    end
    for (int i = 0; i < 20; i++) begin
      drive(i[0] ? 7'h63 : 7'h13, 10'h000, 1'b1);
      n_vec++;
      if ({sel, flush, alu_src, alu_op} !== 7'b01_0_0010) begin
        n_err++; $display("FAIL halt_comb[%0d]: got %b want 0100010", i, {sel, flush, alu_src, alu_op});
      end
      tick();
      n_vec++;
      if ({regwq, memwq, memrq, mem2regq, halted} !== 5'b00001 || retired_cnt !== 32'd14 || flush_cnt !== 32'd4) begin
        n_err++; $display("FAIL halt_hold[%0d]: got %b ret %0d fl %0d want 00001 ret 14 fl 4",
                          i, {regwq, memwq, memrq, mem2regq, halted}, retired_cnt, flush_cnt);
      end
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (halted !== 1'b0 || retired_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_err++; $display("FAIL halt_reset: got halted %b ret %0d fl %0d want 0 0 0", halted, retired_cnt, flush_cnt);
    end
    tick();
  endtask

  task automatic test_wrap;
    rst = 1'b1;
    drive(7'h13, 10'h000, 1'b0);
    for (int i = 0; i < 16; i++) tick();
    n_vec++;
    if (retired_cnt4 !== 4'd0 || retired_cnt !== 32'd16) begin
      n_err++; $display("FAIL wrap_16: got %0d/%0d want 0/16", retired_cnt4, retired_cnt);
    end
    tick();
    n_vec++;
    if (retired_cnt4 !== 4'd1 || retired_cnt !== 32'd17) begin
      n_err++; $display("FAIL wrap_17: got %0d/%0d want 1/17", retired_cnt4, retired_cnt);
    end
    n_vec++;
    if ({sel4, flush4, alu_src4, alu_op4, regwq4, memwq4, memrq4, mem2regq4, halted4, flush_cnt4} !== 17'b0_0_1_0010_1000_0_0000) begin
      n_err++; $display("FAIL wrap_dut4_ctrl: got %b want 00100101000000000",
                        {sel4, flush4, alu_src4, alu_op4, regwq4, memwq4, memrq4, mem2regq4, halted4, flush_cnt4});
    end
    drive(7'h00, 10'h3FF, 1'b1);
    tick(); tick(); tick();
    n_vec++;
    if (retired_cnt4 !== 4'd1 || halted !== 1'b0 || flush !== 1'b0 || regwq !== 1'b0) begin
      n_err++; $display("FAIL wrap_bubble: got ret %0d halted %b flush %b regwq %b want 1 0 0 0", retired_cnt4, halted, flush, regwq);
    end
  endtask

  task automatic test_halt_priority;
    drive(7'h63, {7'h00, 3'b010}, 1'b1);
    n_vec++;
    if ({sel, flush} !== 2'b00) begin
      n_err++; $display("FAIL prio_comb: got %b want 00", {sel, flush});
    end
    tick();
    n_vec++;
    if (halted !== 1'b1 || flush_cnt !== 32'd0 || retired_cnt !== 32'd17) begin
      n_err++; $display("FAIL prio_reg: got halted %b fl %0d ret %0d want 1 0 17", halted, flush_cnt, retired_cnt);
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_async_reset;
    rst = 1'b1;
    drive(7'h23, 10'h000, 1'b0);
    tick();
    n_vec++;
    if (memwq !== 1'b1 || retired_cnt !== 32'd1 || halted !== 1'b0) begin
      n_err++; $display("FAIL async_pre: got memwq %b ret %0d halted %b want 1 1 0", memwq, retired_cnt, halted);
    end
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if (memwq !== 1'b0 || retired_cnt !== 32'd0) begin
      n_err++; $display("FAIL async_drop: got memwq %b ret %0d want 0 0", memwq, retired_cnt);
    end
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst          = 1'b0;
    inst_control = 7'h00;
    inst_alu     = 10'h000;
    zero_flag    = 1'b0;
    test_reset();
    test_decode();
    test_branch();
    test_halt();
    test_wrap();
    test_halt_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
